xor_seq_ctrl: RTL and testbench

XOR_SEQ_CTRL -- requirements
Module: xor_seq_ctrl

---
 rtl/xor_seq_pkg.sv | 22 ++
 rtl/xor_seq_ctrl_if.sv | 26 ++
 rtl/xor_hold_timer.sv | 31 +++
 rtl/xor_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_xor_seq_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/xor_seq_pkg.sv
// Shared definitions for the XOR gate sequencing controller: state encoding,
// vector count and hold-time limits.
package xor_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_VEC      = 4;
    localparam int HOLD_DEFAULT = 4;
    localparam int HOLD_MIN     = 1;
    localparam int HOLD_MAX     = 255;

    // Reference behaviour of the gate under control for a packed {a,b} vector.
    function automatic logic expected_xor(input logic [1:0] ab);
        return ab[1] ^ ab[0];
    endfunction

endpackage

// File: rtl/xor_seq_ctrl_if.sv
// Signal bundle between the controller and its host/gate side.
// The slave modport is the controller; master is the host driving start/abort and the gate returning f53.
interface xor_seq_ctrl_if;

    logic       start;
    logic       abort;
    logic       a;
    logic       b;
    logic       f53;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
    logic [3:0] err_mask;

    modport master (
        output start, abort, f53,
        input  a, b, busy, done, pass, err_cnt, err_mask
    );

    modport slave (
        input  start, abort, f53,
        output a, b, busy, done, pass, err_cnt, err_mask
    );

endinterface

// File: rtl/xor_hold_timer.sv
// Settling-time counter: counts while enabled and flags the last hold cycle (HOLD-1).
// HOLD is legal in 1..255 so the 8-bit counter never wraps before terminal count.
module xor_hold_timer
    import xor_seq_pkg::*;
#(
    parameter int HOLD = HOLD_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [7:0] LAST = 8'(HOLD - 1);

    logic [7:0] hcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
        end else if (clear) begin
            hcnt <= '0;
        end else if (enable) begin
            hcnt <= hcnt + 8'd1;
        end
    end

    assign tc = enable && (hcnt == LAST);

endmodule

// File: rtl/xor_seq_ctrl.sv
// Steps an external XOR gate through all four input vectors, holds each for HOLD cycles,
// samples f53 once per vector and logs mismatches. All outputs are registered.
module xor_seq_ctrl
    import xor_seq_pkg::*;
#(
    parameter int HOLD = HOLD_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    xor_seq_ctrl_if.slave  bus
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_VEC - 1);
    localparam logic [2:0] MAX_ERR  = 3'(NUM_VEC);

    state_t     state, state_nxt;
    logic [1:0] idx, idx_nxt;
    logic       a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
    logic [2:0] err_cnt_nxt;
    logic [3:0] err_mask_nxt;
    logic       tc, timer_clear, timer_en, mismatch;

    assign timer_en    = (state == DRIVE);
    assign timer_clear = (state != DRIVE) || tc;
    assign mismatch    = (bus.f53 != expected_xor({bus.a, bus.b}));

    xor_hold_timer #(.HOLD(HOLD)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .tc     (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            bus.a        <= 1'b0;
            bus.b        <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.pass     <= 1'b0;
            bus.err_cnt  <= '0;
            bus.err_mask <= '0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            bus.a        <= a_nxt;
            bus.b        <= b_nxt;
            bus.busy     <= busy_nxt;
            bus.done     <= done_nxt;
            bus.pass     <= pass_nxt;
            bus.err_cnt  <= err_cnt_nxt;
            bus.err_mask <= err_mask_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (bus.start) state_nxt = DRIVE;
            DRIVE:  if (bus.abort) state_nxt = IDLE;
                    else if (tc)   state_nxt = SAMPLE;
            SAMPLE: if (bus.abort)            state_nxt = IDLE;
                    else if (idx == LAST_IDX) state_nxt = DONE;
                    else                      state_nxt = DRIVE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // done/pass lag the DONE state by one edge so pass sees the final compare.
    always_comb begin
        idx_nxt      = idx;
        a_nxt        = bus.a;
        b_nxt        = bus.b;
        done_nxt     = 1'b0;
        pass_nxt     = bus.pass;
        err_cnt_nxt  = bus.err_cnt;
        err_mask_nxt = bus.err_mask;
        busy_nxt     = (state_nxt == DRIVE) || (state_nxt == SAMPLE);
        case (state)
            IDLE: begin
                if (bus.start) begin
                    idx_nxt      = '0;
                    a_nxt        = 1'b0;
                    b_nxt        = 1'b0;
                    pass_nxt     = 1'b0;
                    err_cnt_nxt  = '0;
                    err_mask_nxt = '0;
                end
            end
            DRIVE: begin
                if (bus.abort) begin
                    a_nxt    = 1'b0;
                    b_nxt    = 1'b0;
                    pass_nxt = 1'b0;
                end
            end
            SAMPLE: begin
                if (bus.abort) begin
                    a_nxt    = 1'b0;
                    b_nxt    = 1'b0;
                    pass_nxt = 1'b0;
                end else begin
                    if (mismatch) begin
                        if (bus.err_cnt != MAX_ERR) err_cnt_nxt = bus.err_cnt + 3'd1;
                        err_mask_nxt[idx] = 1'b1;
                    end
                    if (idx != LAST_IDX) begin
                        idx_nxt        = idx + 2'd1;
                        {a_nxt, b_nxt} = idx + 2'd1;
                    end else begin
                        a_nxt = 1'b0;
                        b_nxt = 1'b0;
                    end
                end
            end
            DONE: begin
                done_nxt = 1'b1;
                pass_nxt = (bus.err_cnt == 3'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_xor_seq_ctrl.sv
// Directed bench for xor_seq_ctrl: HOLD=4 and HOLD=1 instances share clk/rst/start/abort,
// each driven by a behavioural gate whose fault mode selects real XOR, tie-0, tie-1 or XNOR.
module tb_xor_seq_ctrl;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    int   mode  = 0;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    xor_seq_ctrl_if bus4 ();
    xor_seq_ctrl_if bus1 ();

    function automatic logic gate(input int m, input logic a, input logic b);
        case (m)
            0:       return a ^ b;
            1:       return 1'b0;
            2:       return 1'b1;
            default: return ~(a ^ b);
        endcase
    endfunction

    assign bus4.start = start;
    assign bus4.abort = abort;
    assign bus4.f53   = gate(mode, bus4.a, bus4.b);
    assign bus1.start = start;
    assign bus1.abort = abort;
    assign bus1.f53   = gate(mode, bus1.a, bus1.b);

    xor_seq_ctrl #(.HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    xor_seq_ctrl #(.HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-edge request: start/abort are seen by exactly one rising edge.
    task automatic applyStimulus(input logic s, input logic ab);
        start = s;
        abort = ab;
        tick();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic runAndCheck(input string tag, input int m, input logic both, input logic repulse,
                               input int exp_cnt, input int exp_mask, input logic exp_pass);
        mode = m;
        applyStimulus(1'b1, both);
        checkOutput({tag, "_busy_start"}, 32'(bus4.busy), 32'd1);
        checkOutput({tag, "_ab0"}, 32'({bus4.a, bus4.b}), 32'd0);
        for (int k = 1; k <= 22; k++) begin
            start = repulse && (k == 7);
            tick();
            if ((k % 5 == 0) && (k < 20)) checkOutput({tag, "_ab_step"}, 32'({bus4.a, bus4.b}), 32'(k / 5));
            if (k == 20) begin
                checkOutput({tag, "_done_early"}, 32'(bus4.done), 32'd0);
                checkOutput({tag, "_ab_end"}, 32'({bus4.a, bus4.b}), 32'd0);
            end
            if (k == 21) begin
                checkOutput({tag, "_done"}, 32'(bus4.done), 32'd1);
                checkOutput({tag, "_pass"}, 32'(bus4.pass), 32'(exp_pass));
                checkOutput({tag, "_err_cnt"}, 32'(bus4.err_cnt), 32'(exp_cnt));
                checkOutput({tag, "_err_mask"}, 32'(bus4.err_mask), 32'(exp_mask));
            end
            if (k == 22) begin
                checkOutput({tag, "_done_single"}, 32'(bus4.done), 32'd0);
                checkOutput({tag, "_busy_end"}, 32'(bus4.busy), 32'd0);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int seen;
        $display("[TB] start");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ab", 32'({bus4.a, bus4.b}), 32'd0);
        checkOutput("rst_busy", 32'(bus4.busy), 32'd0);
        checkOutput("rst_done", 32'(bus4.done), 32'd0);
        checkOutput("rst_pass", 32'(bus4.pass), 32'd0);
        checkOutput("rst_err_cnt", 32'(bus4.err_cnt), 32'd0);
        checkOutput("rst_err_mask", 32'(bus4.err_mask), 32'd0);
        rst = 1'b0;
        tick();

        runAndCheck("xor",         0, 1'b0, 1'b0, 0, 4'b0000, 1'b1);
        runAndCheck("tie0",        1, 1'b0, 1'b0, 2, 4'b0110, 1'b0);
        runAndCheck("tie1",        2, 1'b0, 1'b0, 2, 4'b1001, 1'b0);
        runAndCheck("xnor",        3, 1'b0, 1'b0, 4, 4'b1111, 1'b0);
        runAndCheck("restart",     0, 1'b0, 1'b1, 0, 4'b0000, 1'b1);
        runAndCheck("start_abort", 0, 1'b1, 1'b0, 0, 4'b0000, 1'b1);

        // Abort in the SAMPLE cycle of vector 10 with f53 tied low: vector 01 already logged,
        // the vector 10 compare must be discarded.
        mode = 1;
        applyStimulus(1'b1, 1'b0);
        repeat (14) tick();
        checkOutput("abort_pre_ab", 32'({bus4.a, bus4.b}), 32'd2);
        checkOutput("abort_pre_err_cnt", 32'(bus4.err_cnt), 32'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("abort_busy", 32'(bus4.busy), 32'd0);
        checkOutput("abort_ab", 32'({bus4.a, bus4.b}), 32'd0);
        checkOutput("abort_pass", 32'(bus4.pass), 32'd0);
        checkOutput("abort_err_cnt", 32'(bus4.err_cnt), 32'd1);
        checkOutput("abort_err_mask", 32'(bus4.err_mask), 32'b0010);
        seen = 0;
        repeat (30) begin
            tick();
            if (bus4.done) seen++;
        end
        checkOutput("abort_no_done", 32'(seen), 32'd0);
        runAndCheck("after_abort", 0, 1'b0, 1'b0, 0, 4'b0000, 1'b1);

        // Asynchronous reset between edges while vector 01 is being driven.
        mode = 2;
        applyStimulus(1'b1, 1'b0);
        repeat (7) tick();
        checkOutput("mid_err_cnt", 32'(bus4.err_cnt), 32'd1);
        checkOutput("mid_ab", 32'({bus4.a, bus4.b}), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_ab", 32'({bus4.a, bus4.b}), 32'd0);
        checkOutput("async_busy", 32'(bus4.busy), 32'd0);
        checkOutput("async_err_cnt", 32'(bus4.err_cnt), 32'd0);
        checkOutput("async_err_mask", 32'(bus4.err_mask), 32'd0);
        checkOutput("async_busy_h1", 32'(bus1.busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        mode = 0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("h1_busy", 32'(bus1.busy), 32'd1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if ((k % 2 == 0) && (k < 8)) checkOutput("h1_ab_step", 32'({bus1.a, bus1.b}), 32'(k / 2));
            if (k == 8) checkOutput("h1_done_early", 32'(bus1.done), 32'd0);
            if (k == 9) begin
                checkOutput("h1_done", 32'(bus1.done), 32'd1);
                checkOutput("h1_pass", 32'(bus1.pass), 32'd1);
                checkOutput("h1_err_cnt", 32'(bus1.err_cnt), 32'd0);
            end
            if (k == 10) checkOutput("h1_done_single", 32'(bus1.done), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
